mb_tx: RTL and testbench

Mainband transmit logical-PHY block for a UCIe x16 link. It accepts 64-byte flits from the adapter side and queues them in a small flit buffer. Each flit is serialized over 16 data lanes in 32 unit intervals, one UI per `clk` cycle. The block drives the valid pin and gates the forwarded clock pins while data is on the wire.

---
 rtl/mb_pkg.sv | 27 ++
 rtl/mb_tx_flit_fifo.sv | 53 +++++
 rtl/mb_tx.sv | 104 ++++++++++
 tb/tb_mb_tx.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mb_pkg.sv
// Shared types and constants for the UCIe x16 mainband transmit path.
package mb_pkg;

  localparam int unsigned MB_LANES    = 16;
  localparam int unsigned FLIT_BYTES  = 64;
  localparam int unsigned UI_PER_FLIT = 32;
  localparam int unsigned UI_W        = $clog2(UI_PER_FLIT);

  // Byte k of a flit is element k; byte 0 goes on the wire first.
  typedef logic [FLIT_BYTES-1:0][7:0] flit_t;

  typedef enum logic {
    ST_IDLE,
    ST_SEND
  } tx_state_e;

  // Lane L in UI u carries bit (u & 7) of byte L + 16*(u >> 3).
  function automatic logic [MB_LANES-1:0] lane_slice(flit_t f, logic [UI_W-1:0] u);
    logic [MB_LANES-1:0] s;
    s = '0;
    for (int unsigned l = 0; l < MB_LANES; l++) begin
      s[l[3:0]] = f[{u[4:3], l[3:0]}][u[2:0]];
    end
    return s;
  endfunction

endpackage

// File: rtl/mb_tx_flit_fifo.sv
// Flit FIFO with wrap-bit pointers; head entry is read combinationally.
module mb_tx_flit_fifo
  import mb_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic  clk_i,
  input  logic  rst_ni,
  input  logic  push_i,
  input  flit_t wdata_i,
  input  logic  pop_i,
  output logic  full_o,
  output logic  empty_o,
  output flit_t rdata_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  flit_t         mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic          do_push, do_pop;

  // Fullness is judged on the pre-pop pointers, so a push racing a pop on a full FIFO is dropped.
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(do_push);
    rd_ptr_d = rd_ptr_q + PW'(do_pop);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end
  end

endmodule

// File: rtl/mb_tx.sv
// Mainband transmit logical PHY: flit capture, 32-UI serializer over 16 lanes, valid and clock gating.
module mb_tx
  import mb_pkg::*;
#(
  parameter int unsigned flit_buffer_size = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                valid_i,
  input  flit_t               data_i,
  input  logic [1:0]          periph_clk_i,
  output logic [1:0]          periph_clkPins_o,
  output logic                valid_pin_o,
  output logic [MB_LANES-1:0] dataPins_o,
  output logic                transmiting_o
);

  localparam logic [UI_W-1:0] UI_LAST = UI_W'(UI_PER_FLIT - 1);

  logic                valid_q;
  logic                push, pop;
  logic                fifo_full, fifo_empty;
  flit_t               fifo_rdata;
  tx_state_e           state_q, state_d;
  logic [UI_W-1:0]     ui_q, ui_d;
  flit_t               hold_q, hold_d;
  logic [MB_LANES-1:0] pins_q, pins_d;
  logic                vpin_q, vpin_d;

  assign push = valid_i && !valid_q;

  mb_tx_flit_fifo #(
    .DEPTH(flit_buffer_size)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (reset),
    .push_i  (push),
    .wdata_i (data_i),
    .pop_i   (pop),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .rdata_o (fifo_rdata)
  );

  // The flit is held and indexed by UI rather than shifted, so one register drives all lanes.
  always_comb begin
    state_d = state_q;
    ui_d    = ui_q;
    hold_d  = hold_q;
    pins_d  = '0;
    vpin_d  = 1'b0;
    pop     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          hold_d  = fifo_rdata;
          state_d = ST_SEND;
          ui_d    = '0;
        end
      end
      ST_SEND: begin
        pins_d = lane_slice(hold_q, ui_q);
        vpin_d = 1'b1;
        if (ui_q == UI_LAST) begin
          ui_d = '0;
          if (!fifo_empty) begin
            pop    = 1'b1;
            hold_d = fifo_rdata;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          ui_d = ui_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= 1'b0;
      state_q <= ST_IDLE;
      ui_q    <= '0;
      hold_q  <= '0;
      pins_q  <= '0;
      vpin_q  <= 1'b0;
    end else begin
      valid_q <= valid_i;
      state_q <= state_d;
      ui_q    <= ui_d;
      hold_q  <= hold_d;
      pins_q  <= pins_d;
      vpin_q  <= vpin_d;
    end
  end

  assign dataPins_o       = pins_q;
  assign valid_pin_o      = vpin_q;
  assign periph_clkPins_o = periph_clk_i & {2{vpin_q}};
  assign transmiting_o    = !fifo_empty || (state_q == ST_SEND);

endmodule

// File: tb/tb_mb_tx.sv
// Directed bench for mb_tx: lane-mapping vector table plus multi-cycle sequences.
module tb_mb_tx;
  import mb_pkg::*;

  logic        clk;
  logic        reset;
  logic        valid_i;
  flit_t       data_i;
  logic [1:0]  periph_clk_i;
  logic [1:0]  periph_clkPins_o;
  logic        valid_pin_o;
  logic [15:0] dataPins_o;
  logic        transmiting_o;

  int n_checks = 0;
  int n_fail   = 0;

  mb_tx #(.flit_buffer_size(4)) dut (
    .clk              (clk),
    .reset            (reset),
    .valid_i          (valid_i),
    .data_i           (data_i),
    .periph_clk_i     (periph_clk_i),
    .periph_clkPins_o (periph_clkPins_o),
    .valid_pin_o      (valid_pin_o),
    .dataPins_o       (dataPins_o),
    .transmiting_o    (transmiting_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Quadrature sources toggling on odd ns; all sampling happens on even ns.
  initial begin
    periph_clk_i[0] = 1'b0;
    #3;
    forever begin
      periph_clk_i[0] = ~periph_clk_i[0];
      #4;
    end
  end
  initial begin
    periph_clk_i[1] = 1'b0;
    #1;
    forever begin
      periph_clk_i[1] = ~periph_clk_i[1];
      #4;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Receiver: rebuilds flits from the pins and tracks valid runs.
  flit_t rx_q[$];
  flit_t cur;
  int    mon_ui = 0, run = 0, last_run = 0, rises = 0, mon_partial = 0;

  always @(negedge clk) begin
    if (!reset) begin
      mon_ui = 0;
      run    = 0;
    end else if (valid_pin_o) begin
      if (run == 0) rises++;
      for (int l = 0; l < 16; l++) begin
        cur[6'(l + 16 * (mon_ui / 8))][3'(mon_ui % 8)] = dataPins_o[4'(l)];
      end
      mon_ui++;
      run++;
      if (mon_ui == 32) begin
        rx_q.push_back(cur);
        mon_ui = 0;
      end
    end else begin
      if (run > 0) last_run = run;
      if (mon_ui != 0) mon_partial++;
      run    = 0;
      mon_ui = 0;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    chk("clk_gate", 64'(periph_clkPins_o), 64'(periph_clk_i & {2{valid_pin_o}}));
  endtask

  task automatic wait_idle(input int max_cycles);
    int n;
    n = 0;
    while ((transmiting_o || valid_pin_o) && n < max_cycles) begin
      tick();
      n++;
    end
    chk("drain_timeout", 64'(transmiting_o || valid_pin_o), 64'(0));
    tick();
  endtask

  task automatic pulse(input flit_t f);
    valid_i = 1'b1;
    data_i  = f;
    tick();
    valid_i = 1'b0;
    tick();
  endtask

  function automatic flit_t make_flit(input int seed);
    flit_t f;
    for (int k = 0; k < 64; k++) f[6'(k)] = 8'(seed * 37 + k * 5 + (k >> 2));
    return f;
  endfunction

  function automatic flit_t make_pat(input int unsigned p);
    flit_t f;
    for (int k = 0; k < 64; k++) begin
      case (p)
        0:       f[6'(k)] = 8'hA5;
        1:       f[6'(k)] = 8'(k);
        2:       f[6'(k)] = (k < 32) ? 8'h0F : 8'hF0;
        default: f[6'(k)] = ((k % 16) < 8) ? 8'h01 : 8'h00;
      endcase
    end
    return f;
  endfunction

  function automatic int count_bad(input flit_t a, input flit_t b);
    int n;
    n = 0;
    for (int k = 0; k < 64; k++) if (a[6'(k)] !== b[6'(k)]) n++;
    return n;
  endfunction

  typedef struct {
    int unsigned pat;
    int unsigned ui;
    logic [15:0] exp_pins;
  } vec_t;

  localparam int NV = 16;
  vec_t vecs [NV];

  initial begin
    flit_t f, hello;
    string s;
    logic [15:0] e;
    int r0, s0;

    vecs[0]  = '{0, 0,  16'hFFFF};
    vecs[1]  = '{0, 3,  16'h0000};
    vecs[2]  = '{0, 21, 16'hFFFF};
    vecs[3]  = '{1, 0,  16'hAAAA};
    vecs[4]  = '{1, 1,  16'hCCCC};
    vecs[5]  = '{1, 4,  16'h0000};
    vecs[6]  = '{1, 8,  16'hAAAA};
    vecs[7]  = '{1, 12, 16'hFFFF};
    vecs[8]  = '{1, 29, 16'hFFFF};
    vecs[9]  = '{1, 31, 16'h0000};
    vecs[10] = '{2, 2,  16'hFFFF};
    vecs[11] = '{2, 19, 16'h0000};
    vecs[12] = '{2, 20, 16'hFFFF};
    vecs[13] = '{3, 0,  16'h00FF};
    vecs[14] = '{3, 24, 16'h00FF};
    vecs[15] = '{3, 1,  16'h0000};

    reset   = 1'b0;
    valid_i = 1'b0;
    data_i  = '0;

    // Reset held: inputs toggle, outputs must stay quiet.
    for (int i = 0; i < 8; i++) begin
      valid_i = ~valid_i;
      data_i  = make_flit(i);
      tick();
      chk("rst_pins", 64'(dataPins_o), 64'(0));
      chk("rst_valid", 64'(valid_pin_o), 64'(0));
      chk("rst_tx", 64'(transmiting_o), 64'(0));
    end
    valid_i = 1'b0;
    reset   = 1'b1;
    repeat (5) tick();
    chk("post_rst_valid", 64'(valid_pin_o), 64'(0));
    chk("post_rst_tx", 64'(transmiting_o), 64'(0));
    chk("post_rst_pins", 64'(dataPins_o), 64'(0));

    // Lane mapping vectors.
    for (int i = 0; i < NV; i++) begin
      f       = make_pat(vecs[i].pat);
      valid_i = 1'b1;
      data_i  = f;
      tick();
      valid_i = 1'b0;
      tick();
      tick();
      chk($sformatf("vec%0d_valid", i), 64'(valid_pin_o), 64'(1));
      repeat (vecs[i].ui) tick();
      chk($sformatf("vec%0d_pins", i), 64'(dataPins_o), 64'(vecs[i].exp_pins));
      wait_idle(64);
    end

    // Single text flit with exact latency and tail timing.
    s = "Hello, World! This is a test. Flit 0";
    for (int k = 0; k < 64; k++) hello[6'(k)] = (k < s.len()) ? s[k] : 8'h20;
    r0      = rx_q.size();
    valid_i = 1'b1;
    data_i  = hello;
    tick();
    chk("hello_tx_after_push", 64'(transmiting_o), 64'(1));
    chk("hello_valid_e0", 64'(valid_pin_o), 64'(0));
    valid_i = 1'b0;
    tick();
    chk("hello_valid_e1", 64'(valid_pin_o), 64'(0));
    tick();
    chk("hello_valid_ui0", 64'(valid_pin_o), 64'(1));
    for (int l = 0; l < 16; l++) e[4'(l)] = hello[6'(l)][0];
    chk("hello_ui0", 64'(dataPins_o), 64'(e));
    repeat (8) tick();
    for (int l = 0; l < 16; l++) e[4'(l)] = hello[6'(l + 16)][0];
    chk("hello_ui8", 64'(dataPins_o), 64'(e));
    repeat (23) tick();
    chk("hello_valid_ui31", 64'(valid_pin_o), 64'(1));
    chk("hello_tx_fall", 64'(transmiting_o), 64'(0));
    tick();
    chk("hello_valid_fall", 64'(valid_pin_o), 64'(0));
    tick();
    chk("hello_run", 64'(last_run), 64'(32));
    chk("hello_count", 64'(rx_q.size() - r0), 64'(1));
    if (rx_q.size() > r0) chk("hello_bytes_bad", 64'(count_bad(rx_q[r0], hello)), 64'(0));

    // Three pulses, serialized back-to-back in order.
    r0 = rx_q.size();
    s0 = rises;
    for (int k = 0; k < 3; k++) pulse(make_flit(30 + k));
    wait_idle(200);
    chk("three_count", 64'(rx_q.size() - r0), 64'(3));
    chk("three_segments", 64'(rises - s0), 64'(1));
    chk("three_run", 64'(last_run), 64'(96));
    for (int k = 0; k < 3; k++)
      if (rx_q.size() > r0 + k) chk($sformatf("three_f%0d_bad", k), 64'(count_bad(rx_q[r0 + k], make_flit(30 + k))), 64'(0));

    // Level hold yields one flit.
    r0      = rx_q.size();
    valid_i = 1'b1;
    data_i  = make_flit(20);
    repeat (100) tick();
    valid_i = 1'b0;
    wait_idle(100);
    chk("hold_count", 64'(rx_q.size() - r0), 64'(1));
    chk("hold_run", 64'(last_run), 64'(32));
    if (rx_q.size() > r0) chk("hold_bytes_bad", 64'(count_bad(rx_q[r0], make_flit(20))), 64'(0));

    // Overflow: 6 pulses at E..E+10, then an offer on the full FIFO's pop edge E+33.
    r0 = rx_q.size();
    s0 = rises;
    for (int k = 0; k < 6; k++) pulse(make_flit(10 + k));
    repeat (21) tick();
    valid_i = 1'b1;
    data_i  = make_flit(16);
    tick();
    valid_i = 1'b0;
    wait_idle(300);
    chk("ovf_count", 64'(rx_q.size() - r0), 64'(5));
    chk("ovf_segments", 64'(rises - s0), 64'(1));
    chk("ovf_run", 64'(last_run), 64'(160));
    for (int k = 0; k < 5; k++)
      if (rx_q.size() > r0 + k) chk($sformatf("ovf_f%0d_bad", k), 64'(count_bad(rx_q[r0 + k], make_flit(10 + k))), 64'(0));

    // Reset at UI10 with two flits still queued.
    pulse(make_flit(40));
    pulse(make_flit(41));
    pulse(make_flit(42));
    repeat (6) tick();
    chk("mid_valid_ui10", 64'(valid_pin_o), 64'(1));
    reset = 1'b0;
    #2;
    chk("mid_rst_pins", 64'(dataPins_o), 64'(0));
    chk("mid_rst_valid", 64'(valid_pin_o), 64'(0));
    chk("mid_rst_tx", 64'(transmiting_o), 64'(0));
    chk("mid_rst_pclk", 64'(periph_clkPins_o), 64'(0));
    repeat (3) tick();
    reset = 1'b1;
    r0    = rx_q.size();
    s0    = rises;
    repeat (50) tick();
    chk("mid_no_resume_valid", 64'(rises - s0), 64'(0));
    chk("mid_no_resume_rx", 64'(rx_q.size() - r0), 64'(0));
    chk("mid_tx_idle", 64'(transmiting_o), 64'(0));
    chk("partial_flits", 64'(mon_partial), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
